// File: rtl/display_hold_buffer.sv
// Change-detecting FIFO between the DataPath X/Y results and the seven-segment driver.
// Each queued pair is held on the display for HOLD_CYCLES cycles so fast updates stay readable.
module display_hold_buffer #(
    parameter int DEPTH       = 8,
    parameter int PTR_W       = 3,
    parameter int HOLD_CYCLES = 100000000,
    parameter int CNT_W       = 27
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             capture_en,
    input  logic [31:0]      in_x,
    input  logic [31:0]      in_y,
    output logic [31:0]      disp_x,
    output logic [31:0]      disp_y,
    output logic             disp_new,
    output logic [PTR_W:0]   fifo_count,
    output logic             overflow
);

    typedef enum logic {IDLE, SHOW} state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);

    logic [63:0]      mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] tail_prev;
    logic [CNT_W-1:0] hold_cnt;
    logic [31:0]      prev_x;
    logic [31:0]      prev_y;
    logic             prev_valid;
    state_t           state;

    logic        push;
    logic        pop;
    logic        full;
    logic        nonempty;
    logic        wr_append;
    logic        wr_over;
    logic [63:0] head_data;

    always_comb begin
        // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
        push      = capture_en & (~prev_valid | ({in_x, in_y} != {prev_x, prev_y}));
        full      = (fifo_count == FULL_COUNT);
        nonempty  = (fifo_count != '0);
        pop       = nonempty & ((state == IDLE) | (hold_cnt == HOLD_LAST));
        wr_append = push & (~full | pop);
        wr_over   = push & full & ~pop;
        tail_prev = tail - PTR_W'(1);
        head_data = mem[head];
    end

    // NOTE: storage array has no reset; its contents are never read before being written.
    always_ff @(posedge Clk) begin
        if (!Rst) begin
            if (wr_append)
                mem[tail] <= {in_x, in_y};
            else if (wr_over)
                mem[tail_prev] <= {in_x, in_y};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            disp_x     <= '0;
            disp_y     <= '0;
            disp_new   <= 1'b0;
            fifo_count <= '0;
            overflow   <= 1'b0;
            head       <= '0;
            tail       <= '0;
            hold_cnt   <= '0;
            prev_x     <= '0;
            prev_y     <= '0;
            prev_valid <= 1'b0;
            state      <= IDLE;
        end else begin
            disp_new <= pop;
            if (pop) begin
                disp_x <= head_data[63:32];
                disp_y <= head_data[31:0];
                head   <= head + PTR_W'(1);
            end
            if (wr_append)
                tail <= tail + PTR_W'(1);
            if (wr_over)
                overflow <= 1'b1;

            case ({wr_append, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase

            // Disabled capture freezes prev, so a change made meanwhile shows up on re-enable.
            if (capture_en) begin
                prev_x     <= in_x;
                prev_y     <= in_y;
                prev_valid <= 1'b1;
            end

            case (state)
                IDLE: begin
                    hold_cnt <= '0;
                    if (pop)
                        state <= SHOW;
                end
                SHOW: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt <= '0;
                        if (!nonempty)
                            state <= IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_display_hold_buffer.sv
// Self-checking bench for display_hold_buffer: directed scenarios plus random traffic,
// compared every cycle against a queue-based reference model.
module tb_display_hold_buffer;

    localparam int DEPTH       = 4;
    localparam int PTR_W       = 2;
    localparam int HOLD_CYCLES = 4;
    localparam int CNT_W       = 3;

    logic             Clk = 1'b0;
    logic             Rst;
    logic             capture_en;
    logic [31:0]      in_x;
    logic [31:0]      in_y;
    logic [31:0]      disp_x;
    logic [31:0]      disp_y;
    logic             disp_new;
    logic [PTR_W:0]   fifo_count;
    logic             overflow;

    display_hold_buffer #(
        .DEPTH(DEPTH), .PTR_W(PTR_W), .HOLD_CYCLES(HOLD_CYCLES), .CNT_W(CNT_W)
    ) dut (
        .Clk(Clk), .Rst(Rst), .capture_en(capture_en), .in_x(in_x), .in_y(in_y),
        .disp_x(disp_x), .disp_y(disp_y), .disp_new(disp_new),
        .fifo_count(fifo_count), .overflow(overflow)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a queue of pending pairs; a pair may be popped once the previous
    // one has been on display for at least HOLD_CYCLES edges.
    typedef struct { logic [31:0] x; logic [31:0] y; } pair_t;
    pair_t       q[$];
    logic [31:0] m_px, m_py, m_dx, m_dy;
    bit          m_pv, m_new, m_ovf, m_ever;
    int          cyc, last_pop;
    int          new_pulses;

    task automatic model_edge(input logic rst, input logic cap, input logic [31:0] x, input logic [31:0] y);
        bit do_push, do_pop;
        cyc++;
        if (rst) begin
            q.delete();
            m_px = 0; m_py = 0; m_dx = 0; m_dy = 0;
            m_pv = 0; m_new = 0; m_ovf = 0; m_ever = 0;
            return;
        end
        do_push = cap && (!m_pv || x != m_px || y != m_py);
        do_pop  = (q.size() > 0) && (!m_ever || cyc - last_pop >= HOLD_CYCLES);
        m_new = do_pop;
        if (do_pop) begin
            m_dx = q[0].x;
            m_dy = q[0].y;
            void'(q.pop_front());
            m_ever   = 1;
            last_pop = cyc;
        end
        if (do_push) begin
            if (q.size() == DEPTH) begin
                q[DEPTH-1] = '{x, y};
                m_ovf = 1;
            end else begin
                q.push_back('{x, y});
            end
        end
        if (cap) begin
            m_px = x; m_py = y; m_pv = 1;
        end
    endtask

    task automatic step(input logic rst, input logic cap, input logic [31:0] x, input logic [31:0] y);
        Rst = rst; capture_en = cap; in_x = x; in_y = y;
        @(posedge Clk);
        model_edge(rst, cap, x, y);
        #1;
        check("disp_x", disp_x, m_dx);
        check("disp_y", disp_y, m_dy);
        check("disp_new", 32'(disp_new), 32'(m_new));
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("overflow", 32'(overflow), 32'(m_ovf));
        if (disp_new) new_pulses++;
    endtask

    task automatic hold(input int n, input logic cap, input logic [31:0] x, input logic [31:0] y);
        for (int i = 0; i < n; i++) step(1'b0, cap, x, y);
    endtask

    initial begin
        cyc = 0; last_pop = 0;
        model_edge(1'b1, 1'b0, 0, 0);
        cyc = 0;

        // Reset with inputs driven high
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step(1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("reset_disp_x", disp_x, 32'd0);

        // Single change: shows after two edges, then stays quiet
        step(1'b0, 1'b1, 32'd5, 32'd7);
        check("single_count_after_push", 32'(fifo_count), 32'd1);
        step(1'b0, 1'b1, 32'd5, 32'd7);
        check("single_disp_x", disp_x, 32'd5);
        check("single_disp_new", 32'(disp_new), 32'd1);
        new_pulses = 0;
        hold(10, 1'b1, 32'd5, 32'd7);
        check("single_no_more_pulses", 32'(new_pulses), 32'd0);

        // Burst of three pairs
        new_pulses = 0;
        step(1'b0, 1'b1, 32'd1, 32'd1);
        step(1'b0, 1'b1, 32'd2, 32'd2);
        step(1'b0, 1'b1, 32'd3, 32'd3);
        hold(20, 1'b1, 32'd3, 32'd3);
        check("burst_pulses", 32'(new_pulses), 32'd3);
        check("burst_final_x", disp_x, 32'd3);

        // Overflow: ten consecutive changes into a four-deep queue
        for (int k = 1; k <= 10; k++) step(1'b0, 1'b1, 32'(k), 32'(k));
        check("ovf_flag", 32'(overflow), 32'd1);
        hold(40, 1'b1, 32'd10, 32'd10);
        check("ovf_final_x", disp_x, 32'd10);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Reset while the second of three pairs is on display
        step(1'b0, 1'b1, 32'd20, 32'd20);
        step(1'b0, 1'b1, 32'd21, 32'd21);
        step(1'b0, 1'b1, 32'd22, 32'd22);
        hold(4, 1'b1, 32'd22, 32'd22);
        check("midshow_second", disp_x, 32'd21);
        step(1'b1, 1'b1, 32'd22, 32'd22);
        check("midshow_reset_count", 32'(fifo_count), 32'd0);
        new_pulses = 0;
        hold(8, 1'b0, 32'd22, 32'd22);
        check("midshow_quiet", 32'(new_pulses), 32'd0);

        // capture_en gating
        hold(3, 1'b1, 32'd9, 32'd9);
        hold(6, 1'b1, 32'd9, 32'd9);
        new_pulses = 0;
        hold(2, 1'b0, 32'd4, 32'd4);
        hold(2, 1'b0, 32'd9, 32'd9);
        hold(6, 1'b1, 32'd9, 32'd9);
        check("gate_no_push", 32'(new_pulses), 32'd0);
        step(1'b0, 1'b1, 32'd4, 32'd4);
        step(1'b0, 1'b1, 32'd4, 32'd4);
        check("gate_reenable_disp", disp_x, 32'd4);

        // Random traffic, including occasional resets and idle stretches
        begin
            logic [31:0] rx, ry;
            rx = 0; ry = 0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    rx = $urandom_range(0, 3);
                    ry = $urandom_range(0, 3);
                end
                if ((i / 200) % 2 == 1 && $urandom_range(0, 7) != 0) begin
                    rx = rx; ry = ry;
                    step(1'b0, 1'b1, rx, ry);
                end else begin
                    step(($urandom_range(0, 249) == 0), ($urandom_range(0, 3) != 0), rx, ry);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
